button_event_decoder: RTL

Consumes the single-cycle pulse stream produced by the button debouncer and decodes it into discrete user-level events: click, double-click, long-press start, auto-repeat and long-press end. It sits between the debouncer and the game/UI control logic, so consumers never need to time pulses themselves. It also takes the synchronized button level so that release can be detected, since the pulse stream alone carries no release information.

---
 rtl/btn_event_pkg.sv | 30 +++
 rtl/release_detector.sv | 47 ++++
 rtl/button_event_decoder.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/btn_event_pkg.sv
// Shared state encoding and default timing constants for the button event path.
// WAIT_SECOND/HOLD2 exist only when BTN_DBL_CLICK_EN is defined.
package btn_event_pkg;

  localparam int CLK_FREQ_HZ     = 50_000_000;
  // 10 ms release qualification and 300 ms double-click window at CLK_FREQ_HZ
  localparam int DEF_RELEASE_THR = CLK_FREQ_HZ / 100;
  localparam int DEF_DCLICK_WIN  = (CLK_FREQ_HZ / 10) * 3;

`ifdef BTN_DBL_CLICK_EN
  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_PRESSED     = 3'd1,
    ST_WAIT_SECOND = 3'd2,
    ST_HOLD2       = 3'd3,
    ST_LONG        = 3'd4
  } btn_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRESSED = 3'd1,
    ST_LONG    = 3'd4
  } btn_state_e;
`endif

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/release_detector.sv
// Counts consecutive low cycles of the button level; flags a release once RELEASE_THR
// of them have been seen. clr (a debouncer pulse) restarts the count.
module release_detector
  import btn_event_pkg::*;
#(
  parameter int RELEASE_THR = DEF_RELEASE_THR
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  input  logic clr,
  output logic released
);

  localparam int            CW   = cnt_width(RELEASE_THR);
  localparam logic [CW-1:0] TERM = CW'(RELEASE_THR - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          released_q, released_d;

  // Counter parks at TERM so a long low period never wraps into a second release.
  always_comb begin
    cnt_d      = cnt_q;
    released_d = 1'b0;
    if (btn || clr) begin
      cnt_d = '0;
    end else begin
      if (cnt_q != TERM) begin
        cnt_d = cnt_q + CW'(1);
      end
      released_d = (cnt_q == TERM);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      released_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      released_q <= released_d;
    end
  end

  assign released = released_q;

endmodule

// File: rtl/button_event_decoder.sv
// Decodes debouncer pulses plus button level into click / double-click / long-press events.
// Double-click support (WAIT_SECOND, HOLD2, window counter) is built only with BTN_DBL_CLICK_EN.
module button_event_decoder
  import btn_event_pkg::*;
#(
  parameter int RELEASE_THR = DEF_RELEASE_THR,
  parameter int DCLICK_WIN  = DEF_DCLICK_WIN,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pulse,
  input  logic             btn,
  output logic             click,
  output logic             dclick,
  output logic             long_start,
  output logic             repeat_pulse,
  output logic             long_end,
  output logic [CNT_W-1:0] rep_count
);

  if (RELEASE_THR < 1 || DCLICK_WIN < 1 || CNT_W < 1) begin : g_param_check
    $error("button_event_decoder: RELEASE_THR, DCLICK_WIN and CNT_W must be >= 1");
  end

  localparam logic [CNT_W-1:0] REP_MAX = {CNT_W{1'b1}};

  btn_state_e       state_q, state_d;
  logic             click_q, click_d;
  logic             long_start_q, long_start_d;
  logic             repeat_q, repeat_d;
  logic             long_end_q, long_end_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic             released;

`ifdef BTN_DBL_CLICK_EN
  localparam int            WW       = cnt_width(DCLICK_WIN);
  localparam logic [WW-1:0] WIN_TERM = WW'(DCLICK_WIN - 1);

  logic          dclick_q, dclick_d;
  logic [WW-1:0] win_q, win_d;
`endif

  release_detector #(
    .RELEASE_THR(RELEASE_THR)
  ) u_release_detector (
    .clk     (clk),
    .reset   (reset),
    .btn     (btn),
    .clr     (pulse),
    .released(released)
  );

  // pulse is tested before released in every state, so a coincident pulse wins.
  always_comb begin
    state_d      = state_q;
    click_d      = 1'b0;
    long_start_d = 1'b0;
    repeat_d     = 1'b0;
    long_end_d   = 1'b0;
    rep_d        = rep_q;
`ifdef BTN_DBL_CLICK_EN
    dclick_d     = 1'b0;
    win_d        = win_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pulse) begin
          state_d = ST_PRESSED;
        end
      end
      ST_PRESSED: begin
        if (pulse) begin
          state_d      = ST_LONG;
          long_start_d = 1'b1;
          rep_d        = '0;
        end else if (released) begin
`ifdef BTN_DBL_CLICK_EN
          state_d = ST_WAIT_SECOND;
          win_d   = '0;
`else
          state_d = ST_IDLE;
          click_d = 1'b1;
`endif
        end
      end
`ifdef BTN_DBL_CLICK_EN
      ST_WAIT_SECOND: begin
        if (pulse) begin
          state_d  = ST_HOLD2;
          dclick_d = 1'b1;
        end else if (win_q == WIN_TERM) begin
          state_d = ST_IDLE;
          click_d = 1'b1;
        end else begin
          win_d = win_q + WW'(1);
        end
      end
      ST_HOLD2: begin
        // Second press of a double-click never escalates to a long press.
        if (!pulse && released) begin
          state_d = ST_IDLE;
        end
      end
`endif
      ST_LONG: begin
        if (pulse) begin
          repeat_d = 1'b1;
          if (rep_q != REP_MAX) begin
            rep_d = rep_q + CNT_W'(1);
          end
        end else if (released) begin
          state_d    = ST_IDLE;
          long_end_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      click_q      <= 1'b0;
      long_start_q <= 1'b0;
      repeat_q     <= 1'b0;
      long_end_q   <= 1'b0;
      rep_q        <= '0;
`ifdef BTN_DBL_CLICK_EN
      dclick_q     <= 1'b0;
      win_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      click_q      <= click_d;
      long_start_q <= long_start_d;
      repeat_q     <= repeat_d;
      long_end_q   <= long_end_d;
      rep_q        <= rep_d;
`ifdef BTN_DBL_CLICK_EN
      dclick_q     <= dclick_d;
      win_q        <= win_d;
`endif
    end
  end

  assign click        = click_q;
  assign long_start   = long_start_q;
  assign repeat_pulse = repeat_q;
  assign long_end     = long_end_q;
  assign rep_count    = rep_q;
`ifdef BTN_DBL_CLICK_EN
  assign dclick       = dclick_q;
`else
  assign dclick       = 1'b0;
`endif

endmodule
